// File: rtl/seg_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_link_pkg
// Description : Shared constants and FSM encodings for the serial segment
//               display link. Both the transmit driver and the receiver use it.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_link_pkg;

   // Bits carried by one frame, i.e. between two parallel-latch pulses
   localparam int SEG_FRAME_BITS = 64;

   // Serial bit order on seg_do: 1 = MSB first
   localparam bit SEG_MSB_FIRST = 1'b1;

   // Receiver frame-assembly state
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_OVER  = 2'd2
   } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : seg_sync_edge
// Description : Multi-flop synchronizer for one asynchronous pin, plus a
//               registered copy of the synced level for rising-edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // Synchronizer chain and one-cycle-delayed copy of its output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~prev;

endmodule
`default_nettype wire

// File: rtl/seg_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg_serial_rx
// Description : Deserializes the seg_clk / seg_do / seg_pen / seg_clr_n link
//               back into parallel frames. All pins are asynchronous to clk.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_serial_rx
   import seg_link_pkg::*;
#(
   parameter int W           = SEG_FRAME_BITS,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seg_clk,
   input  logic             seg_clr_n,
   input  logic             seg_pen,
   input  logic             seg_do,
   output logic [W-1:0]     data_out,
   output logic             frame_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   // Bit counter must hold W+1 to flag an over-long frame
   localparam int BC_W = $clog2(W + 2);

   logic clk_rise, pen_rise, do_s, clr_n_s;
   logic clk_lvl_unused, pen_lvl_unused, do_rise_unused, clr_rise_unused;

   seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .clk(clk), .rst_n(rst_n), .pin(seg_clk),   .level(clk_lvl_unused), .rise(clk_rise));
   seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pen (
      .clk(clk), .rst_n(rst_n), .pin(seg_pen),   .level(pen_lvl_unused), .rise(pen_rise));
   seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_do (
      .clk(clk), .rst_n(rst_n), .pin(seg_do),    .level(do_s),           .rise(do_rise_unused));
   seg_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
      .clk(clk), .rst_n(rst_n), .pin(seg_clr_n), .level(clr_n_s),        .rise(clr_rise_unused));

   seg_state_t        state, state_nxt;
   logic [W-1:0]      shreg, shreg_nxt;
   logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic              latch_ok, latch_bad;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and datapath: clear wins, then shift, then latch on post-shift values
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      latch_ok    = 1'b0;
      latch_bad   = 1'b0;
      if (!clr_n_s) begin
         state_nxt   = S_IDLE;
         shreg_nxt   = '0;
         bit_cnt_nxt = '0;
      end else begin
         if (clk_rise) begin
            shreg_nxt = {shreg[W-2:0], do_s};
            if (bit_cnt != BC_W'(W + 1))
               bit_cnt_nxt = bit_cnt + BC_W'(1);
            case (state)
               S_IDLE:  state_nxt = S_SHIFT;
               S_SHIFT: if (bit_cnt_nxt == BC_W'(W + 1)) state_nxt = S_OVER;
               S_OVER:  state_nxt = S_OVER;
               default: state_nxt = S_IDLE;
            endcase
         end
         if (pen_rise) begin
            if (bit_cnt_nxt == BC_W'(W)) latch_ok  = 1'b1;
            else                         latch_bad = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = S_IDLE;
         end
      end
   end

   // Shift register, bit counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         data_out    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         shreg       <= shreg_nxt;
         bit_cnt     <= bit_cnt_nxt;
         frame_valid <= latch_ok;
         frame_err   <= latch_bad;
         if (latch_ok) begin
            data_out  <= shreg_nxt;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_serial_rx
// Description : Directed self-checking bench for seg_serial_rx. A second,
//               8-bit-frame instance shares the pins for the counter-wrap case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_serial_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seg_clk, seg_clr_n, seg_pen, seg_do;
   logic [63:0] data_out;
   logic        frame_valid, frame_err, busy;
   logic [7:0]  frame_cnt;
   logic [7:0]  data_out8;
   logic        frame_valid8, frame_err8, busy8;
   logic [7:0]  frame_cnt8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg_serial_rx #(.W(64), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk), .seg_clr_n(seg_clr_n),
      .seg_pen(seg_pen), .seg_do(seg_do), .data_out(data_out),
      .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy),
      .frame_cnt(frame_cnt));

   seg_serial_rx #(.W(8), .SYNC_STAGES(2), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk), .seg_clr_n(seg_clr_n),
      .seg_pen(seg_pen), .seg_do(seg_do), .data_out(data_out8),
      .frame_valid(frame_valid8), .frame_err(frame_err8), .busy(busy8),
      .frame_cnt(frame_cnt8));

   task automatic send_bit(input logic b);
      @(negedge clk);
      seg_do  = b;
      seg_clk = 1'b0;
      repeat (4) @(negedge clk);
      seg_clk = 1'b1;
      repeat (4) @(negedge clk);
      seg_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         int idx;
         idx = n - 1 - i;
         send_bit((idx < 64) ? v[idx] : 1'b0);
      end
   endtask

   // Watch 8 cycles for main-DUT pulses: counts and first cycle index seen
   task automatic observe(output int nv, output int ne, output int first);
      nv = 0; ne = 0; first = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (frame_valid) nv++;
         if (frame_err)   ne++;
         if ((frame_valid || frame_err) && first == 0) first = i;
      end
   endtask

   task automatic do_latch(output int nv, output int ne, output int first);
      @(negedge clk);
      seg_pen = 1'b1;
      observe(nv, ne, first);
      seg_pen = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seg_clk = 1'($urandom); seg_pen = 1'($urandom);
         seg_do  = 1'($urandom); seg_clr_n = 1'($urandom);
         #1;
         total++;
         if ({data_out, frame_cnt, busy, frame_valid, frame_err} !== 75'd0) begin
            bad++;
            $display("FAIL reset_hold: out=%h cnt=%0d busy=%b v=%b e=%b required all 0",
                     data_out, frame_cnt, busy, frame_valid, frame_err);
         end
      end
      @(negedge clk);
      seg_clk = 1'b0; seg_pen = 1'b0; seg_do = 1'b0; seg_clr_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if ({data_out, frame_cnt, busy, frame_valid, frame_err} !== 75'd0) begin
         bad++;
         $display("FAIL reset_release: out=%h cnt=%0d busy=%b required idle zeros",
                  data_out, frame_cnt, busy);
      end
   endtask

   task automatic test_good;
      int nv, ne, first;
      send_bits(64'h0123_4567_89AB_CDEF, 64);
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL good_busy: busy=%b required 1", busy); end
      do_latch(nv, ne, first);
      total++;
      if (nv != 1 || ne != 0 || first != 3) begin
         bad++;
         $display("FAIL good_pulse: valid_cycles=%0d err_cycles=%0d first=%0d required 1 0 3", nv, ne, first);
      end
      total++;
      if (data_out !== 64'h0123_4567_89AB_CDEF) begin
         bad++; $display("FAIL good_data: got %h required 0123456789abcdef", data_out);
      end
      total++;
      if (frame_cnt !== 8'd1 || busy !== 1'b0) begin
         bad++; $display("FAIL good_cnt_busy: cnt=%0d busy=%b required 1 0", frame_cnt, busy);
      end
   endtask

   task automatic test_short_long;
      int nv, ne, first;
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 63);
      do_latch(nv, ne, first);
      total++;
      if (nv != 0 || ne != 1) begin
         bad++; $display("FAIL short_pulse: valid=%0d err=%0d required 0 1", nv, ne);
      end
      total++;
      if (data_out !== 64'h0123_4567_89AB_CDEF || frame_cnt !== 8'd1) begin
         bad++; $display("FAIL short_keep: data=%h cnt=%0d required 0123456789abcdef 1", data_out, frame_cnt);
      end
      send_bits(64'h5555_5555_5555_5555, 65);
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL long_busy: busy=%b required 1", busy); end
      do_latch(nv, ne, first);
      total++;
      if (nv != 0 || ne != 1 || busy !== 1'b0) begin
         bad++; $display("FAIL long_pulse: valid=%0d err=%0d busy=%b required 0 1 0", nv, ne, busy);
      end
      total++;
      if (data_out !== 64'h0123_4567_89AB_CDEF || frame_cnt !== 8'd1) begin
         bad++; $display("FAIL long_keep: data=%h cnt=%0d required 0123456789abcdef 1", data_out, frame_cnt);
      end
   endtask

   task automatic test_clear;
      int nv, ne, first;
      send_bits(64'h3FFF_FFFF, 30);
      @(negedge clk); seg_clr_n = 1'b0;
      repeat (5) @(negedge clk);
      seg_clr_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL clear_idle: busy=%b required 0", busy); end
      send_bits(64'hFFFF_0000_AAAA_5555, 64);
      do_latch(nv, ne, first);
      total++;
      if (nv != 1 || ne != 0 || data_out !== 64'hFFFF_0000_AAAA_5555 || frame_cnt !== 8'd2) begin
         bad++;
         $display("FAIL clear_frame: valid=%0d err=%0d data=%h cnt=%0d required 1 0 ffff0000aaaa5555 2",
                  nv, ne, data_out, frame_cnt);
      end
      @(negedge clk); seg_clr_n = 1'b0;
      repeat (4) @(negedge clk);
      do_latch(nv, ne, first);
      seg_clr_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (nv != 0 || ne != 0 || frame_cnt !== 8'd2 || data_out !== 64'hFFFF_0000_AAAA_5555) begin
         bad++;
         $display("FAIL clear_pen: valid=%0d err=%0d cnt=%0d data=%h required 0 0 2 ffff0000aaaa5555",
                  nv, ne, frame_cnt, data_out);
      end
   endtask

   task automatic test_coincident;
      int nv, ne, first;
      logic [63:0] v;
      v = 64'hDEAD_BEEF_CAFE_F00D;
      send_bits(v >> 1, 63);
      @(negedge clk);
      seg_do = v[0];
      repeat (4) @(negedge clk);
      seg_clk = 1'b1;
      seg_pen = 1'b1;
      observe(nv, ne, first);
      seg_clk = 1'b0;
      seg_pen = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (nv != 1 || ne != 0 || data_out !== v || frame_cnt !== 8'd3) begin
         bad++;
         $display("FAIL coincident: valid=%0d err=%0d data=%h cnt=%0d required 1 0 deadbeefcafef00d 3",
                  nv, ne, data_out, frame_cnt);
      end
   endtask

   // 8-bit instance counts 256 good frames; the 64-bit instance sees only errors
   task automatic test_wrap;
      logic [7:0] pat;
      for (int f = 0; f < 256; f++) begin
         pat = 8'(f * 37 + 5);
         send_bits({56'd0, pat}, 8);
         @(negedge clk); seg_pen = 1'b1;
         repeat (4) @(negedge clk);
         seg_pen = 1'b0;
         repeat (4) @(negedge clk);
         if (f == 254) begin
            total++;
            if (frame_cnt8 !== 8'd255) begin
               bad++; $display("FAIL wrap_255: cnt=%0d required 255", frame_cnt8);
            end
         end
      end
      total++;
      if (frame_cnt8 !== 8'd0 || data_out8 !== 8'hE0) begin
         bad++; $display("FAIL wrap_0: cnt=%0d data=%h required 0 e0", frame_cnt8, data_out8);
      end
      total++;
      if (frame_cnt !== 8'd3) begin
         bad++; $display("FAIL wrap_main_keep: cnt=%0d required 3", frame_cnt);
      end
   endtask

   task automatic test_async_reset;
      int nv, ne, first;
      send_bits(64'h000F_FFFF, 20);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({data_out, frame_cnt, busy, frame_valid, frame_err} !== 75'd0) begin
         bad++;
         $display("FAIL async_reset: data=%h cnt=%0d busy=%b required all 0", data_out, frame_cnt, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send_bits(64'h8000_0000_0000_0001, 64);
      do_latch(nv, ne, first);
      total++;
      if (nv != 1 || data_out !== 64'h8000_0000_0000_0001 || frame_cnt !== 8'd1) begin
         bad++;
         $display("FAIL post_reset_frame: valid=%0d data=%h cnt=%0d required 1 8000000000000001 1",
                  nv, data_out, frame_cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0; seg_clk = 1'b0; seg_pen = 1'b0; seg_do = 1'b0; seg_clr_n = 1'b1;
      test_reset();
      test_good();
      test_short_long();
      test_clear();
      test_coincident();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
